// File: rtl/seq_detect_sched.sv
// Time-multiplexed run-of-ones detector shared by N_CH serial requesters via a round-robin arbiter.
// Optional per-channel saturating match counters are enabled with `define MATCH_CNT_EN.
module seq_detect_sched #(
  parameter int N_CH = 4,
  parameter int CH_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   req,
  input  logic [N_CH-1:0]   x,
  input  logic [N_CH-1:0]   clr,
  output logic [N_CH-1:0]   gnt,
  output logic              out_valid,
  output logic              out_y,
  output logic [CH_W-1:0]   out_ch,
  output logic [2*N_CH-1:0] ctx
`ifdef MATCH_CNT_EN
  ,
  output logic [8*N_CH-1:0] match_cnt
`endif
);

  // Gray-like context encoding keeps the run length in two flops per channel.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_ONE  = 2'b01;
  localparam logic [1:0] ST_TWO  = 2'b11;
  localparam logic [1:0] ST_MANY = 2'b10;

  function automatic logic [1:0] det_next(input logic [1:0] s, input logic b);
    logic [1:0] n;
    n = ST_IDLE;
    if (b) begin
      case (s)
        ST_IDLE: n = ST_ONE;
        ST_ONE:  n = ST_TWO;
        default: n = ST_MANY;
      endcase
    end
    return n;
  endfunction

  function automatic logic det_out(input logic [1:0] s, input logic b);
    return (!b) && (s != ST_IDLE);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [CH_W-1:0] ptr_q, ptr_d;
  logic [1:0]      ctx_q [N_CH];
  logic [1:0]      ctx_d [N_CH];
  logic            valid_q;
  logic            y_q, y_d;
  logic [CH_W-1:0] ch_q, ch_d;

  logic [N_CH-1:0] elig;
  logic            hit;
  logic [CH_W-1:0] gidx;
  logic [CH_W:0]   cand;

  // Rotating search from ptr_q+1; clr on a channel suppresses its request.
  always_comb begin
    elig = req & ~clr;
    hit  = 1'b0;
    gidx = '0;
    cand = '0;
    for (int k = 1; k <= N_CH; k++) begin
      cand = {1'b0, ptr_q} + (CH_W+1)'(k);
      if (cand >= (CH_W+1)'(N_CH)) cand = cand - (CH_W+1)'(N_CH);
      if (!hit && elig[cand[CH_W-1:0]]) begin
        hit  = 1'b1;
        gidx = cand[CH_W-1:0];
      end
    end
    if (rst) hit = 1'b0;
  end

  assign gnt = hit ? (N_CH'(1) << gidx) : '0;

  always_comb begin
    ctx_d = ctx_q;
    for (int j = 0; j < N_CH; j++) begin
      if (clr[j]) ctx_d[j] = ST_IDLE;
    end
    y_d   = 1'b0;
    ptr_d = ptr_q;
    ch_d  = ch_q;
    if (hit) begin
      ctx_d[gidx] = det_next(ctx_q[gidx], x[gidx]);
      y_d         = det_out(ctx_q[gidx], x[gidx]);
      ptr_d       = gidx;
      ch_d        = gidx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= CH_W'(N_CH - 1);
      valid_q <= 1'b0;
      y_q     <= 1'b0;
      ch_q    <= '0;
      for (int j = 0; j < N_CH; j++) ctx_q[j] <= ST_IDLE;
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= hit;
      y_q     <= y_d;
      ch_q    <= ch_d;
      ctx_q   <= ctx_d;
    end
  end

  assign out_valid = valid_q;
  assign out_y     = y_q;
  assign out_ch    = ch_q;

  always_comb begin
    ctx = '0;
    for (int j = 0; j < N_CH; j++) ctx[2*j +: 2] = ctx_q[j];
  end

`ifdef MATCH_CNT_EN
  logic [7:0] cnt_q [N_CH];
  logic [7:0] cnt_d [N_CH];

  always_comb begin
    cnt_d = cnt_q;
    for (int j = 0; j < N_CH; j++) begin
      if (clr[j]) cnt_d[j] = 8'd0;
    end
    if (hit && y_d) cnt_d[gidx] = sat_inc(cnt_q[gidx]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < N_CH; j++) cnt_q[j] <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    match_cnt = '0;
    for (int j = 0; j < N_CH; j++) match_cnt[8*j +: 8] = cnt_q[j];
  end
`endif

endmodule

// File: tb/tb_seq_detect_sched.sv
// Scoreboard bench for seq_detect_sched: a behavioural model queues expected grant/result/context per cycle.
module tb_seq_detect_sched;
  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req, x, clr, gnt;
  logic         out_valid, out_y;
  logic [W-1:0] out_ch;
  logic [2*N-1:0] ctx;
`ifdef MATCH_CNT_EN
  logic [8*N-1:0] match_cnt;
`endif

  always #5 clk = ~clk;

  seq_detect_sched #(.N_CH(N), .CH_W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .x(x), .clr(clr), .gnt(gnt),
    .out_valid(out_valid), .out_y(out_y), .out_ch(out_ch), .ctx(ctx)
`ifdef MATCH_CNT_EN
    , .match_cnt(match_cnt)
`endif
  );

  typedef struct packed {
    logic [N-1:0]   gnt;
    logic           vld;
    logic           y;
    logic [W-1:0]   ch;
    logic [2*N-1:0] ctx;
    logic [8*N-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  int         m_ptr;
  logic [1:0] m_ctx [N];
  logic [7:0] m_cnt [N];
  logic [W-1:0] m_ch;

  function automatic logic [1:0] adv(input logic [1:0] s, input logic b);
    if (!b) return 2'b00;
    if (s == 2'b00) return 2'b01;
    if (s == 2'b01) return 2'b11;
    return 2'b10;
  endfunction

  task automatic model_reset();
    m_ptr = N - 1;
    m_ch  = '0;
    for (int i = 0; i < N; i++) begin
      m_ctx[i] = 2'b00;
      m_cnt[i] = 8'd0;
    end
    sb.delete();
  endtask

  task automatic apply(input logic [N-1:0] r, input logic [N-1:0] xx, input logic [N-1:0] c);
    exp_t e;
    int   g;
    logic y;
    req = r; x = xx; clr = c;
    g = -1;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (g < 0 && r[idx] && !c[idx]) g = idx;
    end
    e = '0;
    y = 1'b0;
    if (g >= 0) begin
      e.gnt[g] = 1'b1;
      y = (xx[g] == 1'b0) && (m_ctx[g] != 2'b00);
      m_ctx[g] = adv(m_ctx[g], xx[g]);
      if (y && m_cnt[g] != 8'd255) m_cnt[g] = m_cnt[g] + 8'd1;
      m_ptr = g;
      m_ch  = W'(g);
    end
    for (int j = 0; j < N; j++) begin
      if (c[j]) begin
        m_ctx[j] = 2'b00;
        m_cnt[j] = 8'd0;
      end
    end
    e.vld = (g >= 0);
    e.y   = y;
    e.ch  = m_ch;
    for (int j = 0; j < N; j++) begin
      e.ctx[2*j +: 2] = m_ctx[j];
      e.cnt[8*j +: 8] = m_cnt[j];
    end
    sb.push_back(e);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '1; x = '0; clr = '0;
    #2;
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    tick();
    tick();
    checks++;
    if ({out_valid, out_y, out_ch, ctx} !== 12'd0) begin
      errors++; $display("FAIL reset_outs got vld=%b y=%b ch=%0d ctx=%b exp all zero", out_valid, out_y, out_ch, ctx);
    end
`ifdef MATCH_CNT_EN
    checks++;
    if (match_cnt !== '0) begin errors++; $display("FAIL reset_cnt got=%h exp=0", match_cnt); end
`endif
    req = '0;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_single();
    exp_t e;
    logic [N-1:0] xs [3];
    logic [1:0] cexp [3];
    logic yexp [3];
    xs = '{4'b0001, 4'b0001, 4'b0000};
    cexp = '{2'b01, 2'b11, 2'b00};
    yexp = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      apply(4'b0001, xs[i], 4'b0000);
      e = sb.pop_front();
      checks++;
      if (gnt !== e.gnt) begin errors++; $display("FAIL single_gnt step=%0d got=%b exp=%b", i, gnt, e.gnt); end
      tick();
      checks++;
      if ({out_valid, out_y, out_ch} !== {e.vld, e.y, e.ch}) begin
        errors++; $display("FAIL single_out step=%0d got=%b%b/%0d exp=%b%b/%0d", i, out_valid, out_y, out_ch, e.vld, e.y, e.ch);
      end
      checks++;
      if (ctx[1:0] !== cexp[i] || out_y !== yexp[i] || out_ch !== 2'd0) begin
        errors++; $display("FAIL single_const step=%0d got ctx0=%b y=%b ch=%0d exp ctx0=%b y=%b ch=0", i, ctx[1:0], out_y, out_ch, cexp[i], yexp[i]);
      end
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    logic [1:0] cexp [5];
    logic [N-1:0] xs [5];
    cexp = '{2'b01, 2'b11, 2'b10, 2'b10, 2'b00};
    xs   = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
    for (int i = 0; i < 5; i++) begin
      apply(4'b0010, xs[i], 4'b0000);
      e = sb.pop_front();
      checks++;
      if (gnt !== e.gnt) begin errors++; $display("FAIL sat_gnt step=%0d got=%b exp=%b", i, gnt, e.gnt); end
      tick();
      checks++;
      if ({out_valid, out_y, out_ch, ctx} !== {e.vld, e.y, e.ch, e.ctx}) begin
        errors++; $display("FAIL sat_out step=%0d got=%b%b/%0d ctx=%b exp=%b%b/%0d ctx=%b", i, out_valid, out_y, out_ch, ctx, e.vld, e.y, e.ch, e.ctx);
      end
      checks++;
      if (ctx[3:2] !== cexp[i] || out_y !== (i == 4)) begin
        errors++; $display("FAIL sat_const step=%0d got ctx1=%b y=%b exp ctx1=%b y=%b", i, ctx[3:2], out_y, cexp[i], (i == 4));
      end
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    logic [N-1:0] gexp [7];
    logic [N-1:0] xs [7];
    gexp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
    xs   = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    rst = 1'b1; #1; rst = 1'b0; model_reset();
    for (int i = 0; i < 7; i++) begin
      apply(4'b1111, xs[i], 4'b0000);
      e = sb.pop_front();
      checks++;
      if (gnt !== e.gnt || gnt !== gexp[i]) begin
        errors++; $display("FAIL rr_gnt step=%0d got=%b exp=%b", i, gnt, gexp[i]);
      end
      tick();
      checks++;
      if ({out_valid, out_y, out_ch, ctx} !== {e.vld, e.y, e.ch, e.ctx}) begin
        errors++; $display("FAIL rr_out step=%0d got=%b%b/%0d ctx=%b exp=%b%b/%0d ctx=%b", i, out_valid, out_y, out_ch, ctx, e.vld, e.y, e.ch, e.ctx);
      end
      checks++;
      if (out_y !== (i == 6)) begin errors++; $display("FAIL rr_y step=%0d got=%b exp=%b", i, out_y, (i == 6)); end
    end
  endtask

  task automatic test_clear();
    exp_t e;
    logic [N-1:0] rs [5];
    logic [N-1:0] xs [5];
    logic [N-1:0] cs [5];
    rs = '{4'b1000, 4'b1000, 4'b1000, 4'b1001, 4'b1000};
    xs = '{4'b1000, 4'b1000, 4'b1000, 4'b1001, 4'b0000};
    cs = '{4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0000};
    for (int i = 0; i < 5; i++) begin
      apply(rs[i], xs[i], cs[i]);
      e = sb.pop_front();
      checks++;
      if (gnt !== e.gnt) begin errors++; $display("FAIL clr_gnt step=%0d got=%b exp=%b", i, gnt, e.gnt); end
      tick();
      checks++;
      if ({out_valid, out_y, out_ch, ctx} !== {e.vld, e.y, e.ch, e.ctx}) begin
        errors++; $display("FAIL clr_out step=%0d got=%b%b/%0d ctx=%b exp=%b%b/%0d ctx=%b", i, out_valid, out_y, out_ch, ctx, e.vld, e.y, e.ch, e.ctx);
      end
`ifdef MATCH_CNT_EN
      checks++;
      if (match_cnt !== e.cnt) begin errors++; $display("FAIL clr_cnt step=%0d got=%h exp=%h", i, match_cnt, e.cnt); end
`endif
    end
    checks++;
    if (ctx[7:6] !== 2'b00 || out_y !== 1'b0) begin
      errors++; $display("FAIL clr_final got ctx3=%b y=%b exp ctx3=00 y=0", ctx[7:6], out_y);
    end
  endtask

  task automatic test_idle();
    exp_t e;
    logic [2*N-1:0] ctx0;
    logic [W-1:0] ch0;
    ctx0 = ctx;
    ch0  = out_ch;
    for (int i = 0; i < 3; i++) begin
      apply(4'b0000, 4'b1111, 4'b0000);
      e = sb.pop_front();
      checks++;
      if (gnt !== 4'b0000 || gnt !== e.gnt) begin errors++; $display("FAIL idle_gnt step=%0d got=%b exp=0000", i, gnt); end
      tick();
      checks++;
      if ({out_valid, out_y, out_ch, ctx} !== {1'b0, 1'b0, ch0, ctx0} || ctx !== e.ctx) begin
        errors++; $display("FAIL idle_out step=%0d got=%b%b/%0d ctx=%b exp=00/%0d ctx=%b", i, out_valid, out_y, out_ch, ctx, ch0, ctx0);
      end
    end
    apply(4'b0110, 4'b0000, 4'b0000);
    e = sb.pop_front();
    checks++;
    if (gnt !== e.gnt) begin errors++; $display("FAIL idle_ptr got=%b exp=%b", gnt, e.gnt); end
    tick();
  endtask

  task automatic test_async_reset();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      apply(4'b0001, 4'b0001, 4'b0000);
      e = sb.pop_front();
      tick();
      checks++;
      if (ctx !== e.ctx || out_valid !== e.vld) begin
        errors++; $display("FAIL ar_prep step=%0d got ctx=%b vld=%b exp ctx=%b vld=%b", i, ctx, out_valid, e.ctx, e.vld);
      end
    end
    apply(4'b0011, 4'b0001, 4'b0000);
    e = sb.pop_front();
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({gnt, out_valid, out_y, out_ch, ctx} !== 16'd0) begin
      errors++; $display("FAIL ar_clear got gnt=%b vld=%b y=%b ch=%0d ctx=%b exp all zero", gnt, out_valid, out_y, out_ch, ctx);
    end
`ifdef MATCH_CNT_EN
    checks++;
    if (match_cnt !== '0) begin errors++; $display("FAIL ar_cnt got=%h exp=0", match_cnt); end
`endif
    rst = 1'b0;
    model_reset();
    apply(4'b1111, 4'b0000, 4'b0000);
    e = sb.pop_front();
    checks++;
    if (gnt !== 4'b0001 || gnt !== e.gnt) begin errors++; $display("FAIL ar_first got=%b exp=0001", gnt); end
    tick();
    checks++;
    if ({out_valid, out_y, out_ch, ctx} !== {e.vld, e.y, e.ch, e.ctx}) begin
      errors++; $display("FAIL ar_out got=%b%b/%0d ctx=%b exp=%b%b/%0d ctx=%b", out_valid, out_y, out_ch, ctx, e.vld, e.y, e.ch, e.ctx);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [N-1:0] r, xx, c;
    for (int i = 0; i < 40; i++) begin
      r  = N'($urandom);
      xx = N'($urandom);
      c  = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      apply(r, xx, c);
      e = sb.pop_front();
      checks++;
      if (gnt !== e.gnt) begin errors++; $display("FAIL b2b_gnt step=%0d got=%b exp=%b", i, gnt, e.gnt); end
      tick();
      checks++;
      if ({out_valid, out_y, out_ch, ctx} !== {e.vld, e.y, e.ch, e.ctx}) begin
        errors++; $display("FAIL b2b_out step=%0d got=%b%b/%0d ctx=%b exp=%b%b/%0d ctx=%b", i, out_valid, out_y, out_ch, ctx, e.vld, e.y, e.ch, e.ctx);
      end
`ifdef MATCH_CNT_EN
      checks++;
      if (match_cnt !== e.cnt) begin errors++; $display("FAIL b2b_cnt step=%0d got=%h exp=%h", i, match_cnt, e.cnt); end
`endif
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_saturation();
    test_round_robin();
    test_clear();
    test_idle();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
